// File: rtl/trace_pkg.sv
// Shared op-code constants, dispatcher FSM encoding and op-decode helpers
// for the trace dispatcher.
package trace_pkg;

   localparam logic [3:0] OP_DREAD  = 4'd0;
   localparam logic [3:0] OP_DWRITE = 4'd1;
   localparam logic [3:0] OP_IFETCH = 4'd2;
   localparam logic [3:0] OP_CLR    = 4'd8;
   localparam logic [3:0] OP_PRINT  = 4'd9;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Ops that hold the FIFO head until a cache channel handshake completes.
   function automatic logic op_is_bus(input logic [3:0] op);
      return (op == OP_DREAD) || (op == OP_DWRITE) || (op == OP_IFETCH);
   endfunction

   function automatic logic op_known(input logic [3:0] op);
      return op_is_bus(op) || (op == OP_CLR) || (op == OP_PRINT);
   endfunction

endpackage

// File: rtl/trace_dispatch_if.sv
// Trace dispatcher bus: record input, end-of-trace, I/D cache channels and status.
// bad_cnt exists only when TRACE_DISPATCH_BADOP_CNT_EN is defined.
interface trace_dispatch_if #(
   parameter int AW = 32
);
   logic [3:0]    n;
   logic [AW-1:0] add_in;
   logic          in_valid;
   logic          in_ready;
   logic          done;
   logic          i_valid;
   logic [AW-1:0] i_add;
   logic          i_ready;
   logic          d_valid;
   logic [AW-1:0] d_add;
   logic          d_we;
   logic          d_ready;
   logic          cache_clr;
   logic          print;
   logic          finished;
`ifdef TRACE_DISPATCH_BADOP_CNT_EN
   logic [15:0]   bad_cnt;
`endif

   // Trace source / cache side.
   modport master (
      output n, add_in, in_valid, done, i_ready, d_ready,
      input  in_ready, i_valid, i_add, d_valid, d_add, d_we,
             cache_clr, print, finished
`ifdef TRACE_DISPATCH_BADOP_CNT_EN
      , input bad_cnt
`endif
   );

   // Dispatcher side.
   modport slave (
      input  n, add_in, in_valid, done, i_ready, d_ready,
      output in_ready, i_valid, i_add, d_valid, d_add, d_we,
             cache_clr, print, finished
`ifdef TRACE_DISPATCH_BADOP_CNT_EN
      , output bad_cnt
`endif
   );

endinterface

// File: rtl/trace_fifo.sv
// Trace record FIFO: DEPTH entries of W bits with a combinational head read;
// pointers wrap naturally because DEPTH is a power of two.
module trace_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 36
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == (PW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/trace_dispatch.sv
// Trace dispatcher: queues op records and issues them in order to the I/D cache
// channels or as clear/print pulses. Optional bad-op counter: TRACE_DISPATCH_BADOP_CNT_EN.
module trace_dispatch
   import trace_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic            clk,
   input  logic            clear,
   trace_dispatch_if.slave bus
);
   localparam int W  = 4 + AW;
   localparam int CW = $clog2(DEPTH) + 1;

   state_t        state_reg, state_next;
   logic          i_valid_reg, i_valid_next;
   logic          d_valid_reg, d_valid_next;
   logic          d_we_reg, d_we_next;
   logic [AW-1:0] i_add_reg, i_add_next;
   logic [AW-1:0] d_add_reg, d_add_next;
   logic          cache_clr_reg, cache_clr_next;
   logic          print_reg, print_next;
   logic          finished_reg, finished_next;
   logic          done_seen_reg;

   logic [W-1:0]  head;
   logic [3:0]    head_op;
   logic [AW-1:0] head_add;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_after;
   logic          push, pop, load, hs, busy, active, done_now, drained;

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .clear (clear),
      .push  (push),
      .din   ({bus.n, bus.add_in}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_op     = head[W-1 -: 4];
   assign head_add    = head[AW-1:0];
   assign bus.in_ready = !fifo_full && (state_reg != DONE);
   assign push        = bus.in_valid && bus.in_ready;
   assign busy        = i_valid_reg || d_valid_reg;
   assign hs          = (i_valid_reg && bus.i_ready) || (d_valid_reg && bus.d_ready);
   assign active      = state_reg inside {IDLE, ISSUE, DRAIN};
   // A new head is only picked up once the previous bus transfer has completed.
   assign load        = active && !busy && !fifo_empty;
   assign pop         = hs || (load && !op_is_bus(head_op));
   assign count_after = fifo_count + CW'(push) - CW'(pop);
   assign done_now    = done_seen_reg || bus.done;
   // Holding off while an op-9 pulse is high keeps the final print a separate pulse.
   assign drained     = fifo_empty && !push && !print_reg;

   always_comb begin
      state_next     = state_reg;
      i_valid_next   = i_valid_reg;
      d_valid_next   = d_valid_reg;
      d_we_next      = d_we_reg;
      i_add_next     = i_add_reg;
      d_add_next     = d_add_reg;
      cache_clr_next = 1'b0;
      print_next     = 1'b0;
      finished_next  = finished_reg;

      if (hs) begin
         i_valid_next = 1'b0;
         d_valid_next = 1'b0;
      end

      if (load) begin
         case (head_op)
            OP_DREAD: begin
               d_valid_next = 1'b1;
               d_we_next    = 1'b0;
               d_add_next   = head_add;
            end
            OP_DWRITE: begin
               d_valid_next = 1'b1;
               d_we_next    = 1'b1;
               d_add_next   = head_add;
            end
            OP_IFETCH: begin
               i_valid_next = 1'b1;
               i_add_next   = head_add;
            end
            OP_CLR:   cache_clr_next = 1'b1;
            OP_PRINT: print_next     = 1'b1;
            default:  ;
         endcase
      end

      case (state_reg)
         IDLE: begin
            if (done_now) begin
               state_next = drained ? FINAL : DRAIN;
            end else if (!fifo_empty) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (done_now) begin
               state_next = DRAIN;
            end else if (count_after == '0) begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (drained) begin
               state_next = FINAL;
            end
         end
         FINAL:   state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase

      if ((state_next == FINAL) && (state_reg != FINAL)) begin
         print_next = 1'b1;
      end
      finished_next = (state_next == DONE);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_reg     <= IDLE;
         i_valid_reg   <= 1'b0;
         d_valid_reg   <= 1'b0;
         d_we_reg      <= 1'b0;
         i_add_reg     <= '0;
         d_add_reg     <= '0;
         cache_clr_reg <= 1'b0;
         print_reg     <= 1'b0;
         finished_reg  <= 1'b0;
         done_seen_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         i_valid_reg   <= i_valid_next;
         d_valid_reg   <= d_valid_next;
         d_we_reg      <= d_we_next;
         i_add_reg     <= i_add_next;
         d_add_reg     <= d_add_next;
         cache_clr_reg <= cache_clr_next;
         print_reg     <= print_next;
         finished_reg  <= finished_next;
         done_seen_reg <= done_seen_reg || bus.done;
      end
   end

   assign bus.i_valid   = i_valid_reg;
   assign bus.i_add     = i_add_reg;
   assign bus.d_valid   = d_valid_reg;
   assign bus.d_add     = d_add_reg;
   assign bus.d_we      = d_we_reg;
   assign bus.cache_clr = cache_clr_reg;
   assign bus.print     = print_reg;
   assign bus.finished  = finished_reg;

`ifdef TRACE_DISPATCH_BADOP_CNT_EN
   logic [15:0] bad_cnt_reg;
   logic        drop;

   assign drop = load && !op_known(head_op);

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         bad_cnt_reg <= '0;
      end else if (load && (head_op == OP_CLR)) begin
         bad_cnt_reg <= '0;
      end else if (drop && (bad_cnt_reg != 16'hFFFF)) begin
         bad_cnt_reg <= bad_cnt_reg + 16'd1;
      end
   end

   assign bus.bad_cnt = bad_cnt_reg;
`endif

endmodule

// File: tb/tb_trace_dispatch.sv
// Directed bench for trace_dispatch: a scoreboard queue of expected dispatch events
// is filled at record acceptance and drained by a negedge monitor.
module tb_trace_dispatch;
   import trace_pkg::*;

   localparam int AW = 32;
   localparam logic [1:0] K_D   = 2'd0;
   localparam logic [1:0] K_I   = 2'd1;
   localparam logic [1:0] K_CLR = 2'd2;
   localparam logic [1:0] K_PRT = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic        we;
      logic [31:0] add;
   } exp_t;

   logic clk   = 1'b0;
   logic clear = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   trace_dispatch_if #(.AW(AW)) bus ();

   trace_dispatch #(
      .DEPTH (4),
      .AW    (AW)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] k, input logic we, input logic [31:0] a);
      exp_t e;
      e.kind = k;
      e.we   = we;
      e.add  = a;
      return e;
   endfunction

   function automatic void expect_op(input logic [3:0] op, input logic [31:0] a);
      case (op)
         OP_DREAD:  sb.push_back(mk(K_D, 1'b0, a));
         OP_DWRITE: sb.push_back(mk(K_D, 1'b1, a));
         OP_IFETCH: sb.push_back(mk(K_I, 1'b0, a));
         OP_CLR:    sb.push_back(mk(K_CLR, 1'b0, 32'h0));
         OP_PRINT:  sb.push_back(mk(K_PRT, 1'b0, 32'h0));
         default:   ;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input logic [1:0] k, input logic we, input logic [31:0] a);
      exp_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL sb_unexpected: observed kind %0d we %0b add %h expected no event", k, we, a);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         assert (mk(k, we, a) === e) else begin
            n_err++;
            $error("FAIL sb_event: observed kind %0d we %0b add %h expected kind %0d we %0b add %h",
                   k, we, a, e.kind, e.we, e.add);
         end
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Drives one record and holds it until accepted (bounded wait).
   task automatic push_rec(input logic [3:0] op, input logic [31:0] a);
      logic rdy;
      int   guard;
      guard       = 0;
      rdy         = 1'b0;
      bus.n       = op;
      bus.add_in  = a;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!rdy && guard < 40);
      bus.in_valid = 1'b0;
      n_cmp++;
      assert (rdy) else begin
         n_err++;
         $error("FAIL push_accept: observed in_ready=0 for %0d cycles expected acceptance", guard);
      end
      if (rdy) expect_op(op, a);
   endtask

   task automatic wait_drain(input string tag);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         step(1);
         guard++;
      end
      check(tag, sb.size(), 0);
   endtask

   task automatic wait_finished(input string tag);
      int guard;
      guard = 0;
      while (bus.finished !== 1'b1 && guard < 100) begin
         step(1);
         guard++;
      end
      check(tag, bus.finished, 1);
   endtask

   always @(negedge clk) begin
      if (!clear) begin
         n_cmp++;
         assert (!(bus.i_valid && bus.d_valid)) else begin
            n_err++;
            $error("FAIL both_valid: observed i_valid=%0b d_valid=%0b expected at most one",
                   bus.i_valid, bus.d_valid);
         end
         if (bus.d_valid && bus.d_ready) sb_check(K_D, bus.d_we, bus.d_add);
         if (bus.i_valid && bus.i_ready) sb_check(K_I, 1'b0, bus.i_add);
         if (bus.cache_clr) sb_check(K_CLR, 1'b0, 32'h0);
         if (bus.print) sb_check(K_PRT, 1'b0, 32'h0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test expected end within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.n = 4'd0; bus.add_in = '0; bus.in_valid = 1'b0; bus.done = 1'b0;
      bus.i_ready = 1'b0; bus.d_ready = 1'b0;

      // Reset state
      clear = 1'b1;
      step(3);
      check("rst_i_valid", bus.i_valid, 0);
      check("rst_d_valid", bus.d_valid, 0);
      check("rst_d_we", bus.d_we, 0);
      check("rst_i_add", bus.i_add, 0);
      check("rst_d_add", bus.d_add, 0);
      check("rst_cache_clr", bus.cache_clr, 0);
      check("rst_print", bus.print, 0);
      check("rst_finished", bus.finished, 0);
      clear = 1'b0;
      step(1);
      check("rst_in_ready", bus.in_ready, 1);
`ifdef TRACE_DISPATCH_BADOP_CNT_EN
      check("rst_bad_cnt", bus.bad_cnt, 0);
`endif

      // Instruction fetch latency
      bus.i_ready = 1'b1; bus.d_ready = 1'b1;
      push_rec(OP_IFETCH, 32'h0000_1000);
      check("fetch_not_yet", bus.i_valid, 0);
      step(1);
      check("fetch_i_valid", bus.i_valid, 1);
      check("fetch_i_add", bus.i_add, 32'h0000_1000);
      check("fetch_d_valid", bus.d_valid, 0);
      step(1);
      check("fetch_popped", bus.i_valid, 0);

      // Data write held against d_ready low
      bus.d_ready = 1'b0;
      push_rec(OP_DWRITE, 32'hDEAD_BEE0);
      step(1);
      for (int k = 0; k < 5; k++) begin
         check("hold_d_valid", bus.d_valid, 1);
         check("hold_d_we", bus.d_we, 1);
         check("hold_d_add", bus.d_add, 32'hDEAD_BEE0);
         step(1);
      end
      bus.d_ready = 1'b1;
      step(1);
      check("hold_released", bus.d_valid, 0);
      wait_drain("hold_drain");

      // Full FIFO back-pressure and ordering across pointer wrap
      bus.i_ready = 1'b0; bus.d_ready = 1'b0;
      push_rec(OP_DREAD,  32'hA000_0000);
      push_rec(OP_DWRITE, 32'hA000_0004);
      push_rec(OP_IFETCH, 32'hA000_0008);
      push_rec(OP_DREAD,  32'hA000_000C);
      check("full_in_ready", bus.in_ready, 0);
      fork
         push_rec(OP_DWRITE, 32'hA000_0010);
         begin
            step(3);
            check("full_held", bus.in_ready, 0);
            bus.i_ready = 1'b1;
            bus.d_ready = 1'b1;
         end
      join
      wait_drain("order_drain");
      step(2);

      // Pulses and a dropped op
      push_rec(OP_CLR, 32'h0000_0000);
      push_rec(OP_PRINT, 32'h0000_0000);
      push_rec(4'd5, 32'h0000_0005);
      wait_drain("pulse_drain");
      step(2);
      check("pulse_clr_low", bus.cache_clr, 0);
      check("pulse_print_low", bus.print, 0);
`ifdef TRACE_DISPATCH_BADOP_CNT_EN
      check("bad_cnt_one", bus.bad_cnt, 1);
`endif

      // Done with records pending
      push_rec(OP_DREAD, 32'hB000_0000);
      push_rec(OP_DREAD, 32'hB000_0004);
      push_rec(OP_DREAD, 32'hB000_0008);
      bus.done = 1'b1;
      sb.push_back(mk(K_PRT, 1'b0, 32'h0));
      step(1);
      bus.done = 1'b0;
      wait_finished("drain_finished");
      check("drain_in_ready", bus.in_ready, 0);
      check("drain_i_valid", bus.i_valid, 0);
      check("drain_d_valid", bus.d_valid, 0);
      step(3);
      check("drain_sticky", bus.finished, 1);
      check("drain_sb_empty", sb.size(), 0);

      // Clear in the middle of a pending data handshake
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      step(1);
      check("clr1_finished", bus.finished, 0);
      check("clr1_in_ready", bus.in_ready, 1);
      bus.d_ready = 1'b0;
      push_rec(OP_DREAD, 32'hC0DE_0000);
      step(1);
      check("pre_clr_d_valid", bus.d_valid, 1);
      #2 clear = 1'b1;
      #1;
      sb.delete();
      check("clr_d_valid", bus.d_valid, 0);
      check("clr_d_add", bus.d_add, 0);
      check("clr_finished", bus.finished, 0);
      step(1);
      clear = 1'b0;
      check("clr_in_ready", bus.in_ready, 1);
      bus.d_ready = 1'b1;
      step(4);
      check("clr_quiet", bus.d_valid, 0);

      // Record and done in the same cycle
      bus.done = 1'b1;
      push_rec(OP_DREAD, 32'hE000_0000);
      bus.done = 1'b0;
      sb.push_back(mk(K_PRT, 1'b0, 32'h0));
      wait_finished("same_cycle_finished");
      step(2);
      check("same_cycle_sb", sb.size(), 0);

      // Done on an empty FIFO goes straight to the final print
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      step(1);
      bus.done = 1'b1;
      sb.push_back(mk(K_PRT, 1'b0, 32'h0));
      step(1);
      bus.done = 1'b0;
      check("idle_final_print", bus.print, 1);
      check("idle_final_not_fin", bus.finished, 0);
      step(1);
      check("idle_done_print", bus.print, 0);
      check("idle_done_finished", bus.finished, 1);
      check("idle_done_in_ready", bus.in_ready, 0);
      step(2);
      check("idle_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/trace_dispatch.md
TRACE_DISPATCH -- requirements
Module: trace_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning trace FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: clear  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: n  in  4  trace op code; add_in  in  AW  trace address; in_valid  in  1; in_ready  out  1.
REQ-006 SHALL have ports: done  in  1  end-of-trace indication, level, sampled each cycle.
REQ-007 SHALL have ports: i_valid  out  1; i_add  out  AW; i_ready  in  1  (instruction-cache fetch channel).
REQ-008 SHALL have ports: d_valid  out  1; d_add  out  AW; d_we  out  1; d_ready  in  1  (data-cache channel).
REQ-009 SHALL have ports: cache_clr  out  1  one-cycle pulse; print  out  1  one-cycle pulse; finished  out  1  level.

Function
REQ-010 SHALL accept a record when in_valid && in_ready on a rising edge; in_ready = (count < DEPTH) && state != DONE, with no same-cycle bypass when full.
REQ-011 SHALL dispatch records strictly in arrival order from the FIFO head; head is popped only on its completion event.
REQ-012 SHALL decode op 0 -> d_valid, d_we=0; op 1 -> d_valid, d_we=1; op 2 -> i_valid; op 8 -> cache_clr pulse; op 9 -> print pulse; ops 3-7, 10-15 -> dropped in one cycle, no output.
REQ-013 SHALL drive i_valid/d_valid from registers; a record accepted at edge T into an empty FIFO presents valid after edge T+1.
REQ-014 SHALL hold valid, address and d_we stable until the matching ready is sampled high; pop occurs on that edge.
REQ-015 SHALL never assert i_valid and d_valid in the same cycle.
REQ-016 SHALL pulse cache_clr or print for exactly one cycle per op 8/op 9 record, popping it on the same edge.
REQ-017 SHALL use state machine IDLE (FIFO empty), ISSUE (head being dispatched), DRAIN (done seen, FIFO non-empty), FINAL (one-cycle print pulse), DONE.
REQ-018 SHALL transition IDLE->ISSUE on non-empty; ISSUE->IDLE when last entry pops; any->DRAIN when done sampled high with entries pending; DRAIN->FINAL when FIFO empty and no valid outstanding; IDLE->FINAL directly on done; FINAL->DONE unconditionally.
REQ-019 SHALL in DONE hold in_ready=0, finished=1, all valids 0 until clear.
REQ-020 SHALL keep done sticky internally; deassertion after first sampling has no effect.
REQ-021 SHALL, on simultaneous push and pop with count non-zero, keep count unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL, when done and in_valid are high in the same cycle with in_ready high, accept that record before draining.

Reset
REQ-023 SHALL on clear asserted (any time, including mid-handshake) immediately force: FIFO empty, pointers 0, state IDLE, i_valid=0, d_valid=0, d_we=0, i_add=0, d_add=0, cache_clr=0, print=0, finished=0, sticky done=0; in_ready=1 after release.

Configuration
REQ-024 SHALL, with macro TRACE_DISPATCH_BADOP_CNT_EN defined, add output bad_cnt (16 bits, reset 0) incrementing once per dropped op, saturating at 16'hFFFF, and cleared by an op 8 record.
REQ-025 SHALL, without TRACE_DISPATCH_BADOP_CNT_EN, have no bad_cnt port and no counter logic; behaviour otherwise identical.

Structure
REQ-026 SHALL take op-code constants (OP_DREAD=0, OP_DWRITE=1, OP_IFETCH=2, OP_CLR=8, OP_PRINT=9) and the state encoding from shared package trace_pkg.
REQ-027 SHALL implement storage in one sub-module trace_fifo (DEPTH x (4+AW), push/pop/full/empty/count); decode and FSM live in trace_dispatch.

Verification
REQ-028 Push op2 add 0x0000_1000, i_ready=1 -> i_valid high one cycle after accept, i_add=0x0000_1000, d_valid stays 0.
REQ-029 Push op1 0xDEAD_BEE0, d_ready=0 for 5 cycles then 1 -> d_valid/d_we/d_add stable 5 cycles, pop on 6th edge.
REQ-030 Push 5 records, all readies 0, DEPTH=4 -> in_ready low after 4th accept; 5th held; ordering preserved on release.
REQ-031 Push op8, op9, op5 -> cache_clr one-cycle pulse, then print one-cycle pulse, op5 silently dropped (bad_cnt=1 when macro on).
REQ-032 Push 3 data reads, assert done one cycle -> all 3 dispatched, then print pulse once, finished=1, in_ready=0.
REQ-033 Assert clear while d_valid high awaiting ready -> same-cycle d_valid=0, FIFO empty, state IDLE, finished=0.
